sa_result_drain: RTL and testbench
==================================

// Module: sa_result_drain
// PURPOSE
//   Consumer end of the SA_CORE result interface. Watches per-row result-valid flags and
//   acknowledges with a one-cycle outread pulse. Captures the valid row results into a
//   local buffer, then serialises them onto a valid/ready stream tagged with row index.
//   Sits between the systolic core and the writeback/DMA path.
// PARAMETERS
//   ROWS   8    number of array rows (result lanes)
//   DW     32   result word width
//   RW     $clog2(ROWS)  row-index tag width (derived, localparam)
// PORTS
//   clk         in   1        clock, all logic on posedge
//   rst         in   1        synchronous, active-high reset
//   routport    in   DW x ROWS   per-row accumulated results from core
//   rvalidport  in   ROWS     per-row result valid from core (bit r = row r)
//   outread     out  1        read-acknowledge to core, one-cycle pulse
//   m_data      out  DW       serialised result word
//   m_row       out  RW       row index of m_data
//   m_last      out  1        final beat of the current capture
//   m_valid     out  1        stream valid
//   m_ready     in   1        stream ready from downstream
//   busy        out  1        high whenever state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, mask=0, outread=0, m_valid=0, m_last=0, m_data=0, m_row=0, busy=0.
//     Reset mid-drain discards the buffer; no further beats are emitted for it.
//   Core contract: core holds routport/rvalidport stable until it samples outread=1 at a
//     posedge. From the next cycle it clears the acknowledged rows.
//   FSM IDLE -> DRAIN:
//     In IDLE, at a posedge with rvalidport!=0 and outread==0:
//       buf[r] <= routport[r]; mask <= rvalidport; outread <= 1; state <= DRAIN.
//     rvalidport is never sampled while outread==1, so one result set is never captured twice.
//   outread: registered; high for exactly one cycle following the capture edge; else 0.
//   DRAIN:
//     m_valid=1 and m_row=idx, where idx = lowest set bit of mask; m_data=buf[idx].
//     m_last=1 iff popcount(mask)==1.
//     Outputs are combinational from registered mask/buf and stay stable while m_ready=0.
//     On m_valid&&m_ready: clear mask[idx].
//     If that was the last beat: state <= IDLE and m_valid drops the next cycle.
//   Latency: capture edge E0 -> outread and first m_valid both high in cycle E0..E1.
//     With m_ready held at 1, N valid rows take N cycles; the next capture is possible at E0+N+1.
//   Gaps: rows absent in mask are skipped; row order is always ascending index.
//   New rvalid during DRAIN: ignored until return to IDLE. Core holds it, so nothing is lost.
//   Backpressure: m_ready=0 indefinitely holds state. No timeout.
//   Widths: no arithmetic on data; m_data is a bit-exact copy of the captured word.
// STRUCTURE
//   sa_pkg (shared): SA_ROWS, SA_DW defaults, typedef sa_word_t [DW-1:0],
//     enum drain_state_t {IDLE, DRAIN}.
//   Sub-module sa_prio_enc: ROWS-bit mask -> lowest-set index (RW bits) + any + onehot.
//     Reused by the input skew feeder.
//   Top: FSM, ROWS x DW buffer, mask register, outread register, output mux.
// TESTING
//   1 Reset: rst=1 for 3 cycles with rvalidport=8'hFF.
//     -> outread=0, m_valid=0, busy=0 throughout.
//   2 Full capture: rvalidport=8'hFF, routport[r]=100+r, m_ready=1.
//     -> one outread pulse, then 8 beats in consecutive cycles with m_row 0..7,
//        m_data 100..107, m_last only on row 7.
//   3 Sparse: rvalidport=8'b1010_0100, routport[r]=r*3.
//     -> 3 beats: (row2,6), (row5,15), (row7,21,last).
//   4 Backpressure: as in 2, but m_ready toggles 0/1 every cycle.
//     -> 8 beats over 16 cycles, same data, outputs stable during m_ready=0.
//   5 Back-to-back: core model re-asserts 8'h03 with values 7,9 immediately after clearing.
//     -> second outread is not before E0+3; beats (0,7),(1,9); no duplicate capture.
//   6 Reset mid-drain: rst pulsed after 3 of 8 beats.
//     -> m_valid=0 the next cycle, busy=0, no remaining beats.
//   Checkers: outread is never high two cycles in a row; beat count per capture equals
//     popcount(capture mask).

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array result path: default geometry,
// result word type and the drain FSM state encoding.
package sa_pkg;

  localparam int unsigned SA_ROWS = 8;
  localparam int unsigned SA_DW   = 32;

  typedef logic [SA_DW-1:0] sa_word_t;

  typedef enum logic {
    StIdle,
    StDrain
  } drain_state_t;

endpackage

// File: rtl/sa_prio_enc.sv
// Lowest-set-bit priority encoder: returns binary index, any-set flag and the
// isolated lowest bit as a one-hot vector.
module sa_prio_enc #(
  parameter  int unsigned ROWS = 8,
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [ROWS-1:0] mask,
  output logic [RW-1:0]   idx,
  output logic            any,
  output logic [ROWS-1:0] onehot
);

  always_comb begin
    idx    = '0;
    onehot = '0;
    any    = |mask;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx       = RW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sa_result_drain.sv
// Captures a set of per-row core results with a one-cycle acknowledge, then
// streams the valid rows in ascending order on a valid/ready interface.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter  int unsigned ROWS = SA_ROWS,
  parameter  int unsigned DW   = SA_DW,
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROWS-1:0][DW-1:0]  routport,
  input  logic [ROWS-1:0]          rvalidport,
  output logic                     outread,
  output logic [DW-1:0]            m_data,
  output logic [RW-1:0]            m_row,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy
);

  drain_state_t              state_q, state_d;
  logic [ROWS-1:0]           mask_q, mask_d;
  logic [ROWS-1:0][DW-1:0]   buf_q;
  logic                      outread_q, outread_d;

  logic [RW-1:0]             sel_idx;
  logic                      mask_any;
  logic [ROWS-1:0]           sel_onehot;
  logic                      single;
  logic                      capture;

  sa_prio_enc #(
    .ROWS (ROWS)
  ) u_prio_enc (
    .mask   (mask_q),
    .idx    (sel_idx),
    .any    (mask_any),
    .onehot (sel_onehot)
  );

  // Exactly one row left when the mask equals its own lowest set bit.
  assign single  = mask_any && (mask_q == sel_onehot);
  // outread gating keeps a still-held result set from being captured twice.
  assign capture = (state_q == StIdle) && (|rvalidport) && !outread_q;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    outread_d = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_row     = '0;
    m_last    = 1'b0;
    case (state_q)
      StIdle: begin
        if (capture) begin
          mask_d    = rvalidport;
          outread_d = 1'b1;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        m_valid = 1'b1;
        m_row   = sel_idx;
        m_data  = buf_q[sel_idx];
        m_last  = single;
        if (m_ready) begin
          mask_d = mask_q & ~sel_onehot;
          if (single) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      outread_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      outread_q <= outread_d;
    end
  end

  // Data buffer needs no reset: it is only read under a non-zero mask.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      buf_q <= routport;
    end
  end

  assign outread = outread_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain: a holding core model feeds result sets and a
// queue-based reference predicts acknowledge timing and the beat stream.
module tb_sa_result_drain;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0][31:0] routport;
  logic [7:0]       rvalidport;
  logic             outread;
  logic [31:0]      m_data;
  logic [2:0]       m_row;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;
  logic             busy;

  always #5 clk = ~clk;

  sa_result_drain #(
    .ROWS (8),
    .DW   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .routport   (routport),
    .rvalidport (rvalidport),
    .outread    (outread),
    .m_data     (m_data),
    .m_row      (m_row),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] row;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [7:0]       mask;
    logic [7:0][31:0] data;
  } set_t;

  set_t        core_q[$];
  beat_t       exp_q[$];
  bit          ack;
  int          checks, errors, cyc;
  int          beats_seen, beats_exp;
  int          or_cycles[$];
  int          ready_mode;
  bit          hold, obs_hs;
  logic [31:0] held_data;
  logic [2:0]  held_row;
  logic        last_or;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, advance the reference at the edge,
  // then let the core model and ready policy drive the next cycle.
  task automatic cycle();
    bit exp_valid, prev_ack, new_ack;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0);
    check("outread", outread, ack);
    check("busy", busy, exp_valid);
    check("m_valid", m_valid, exp_valid);
    if (exp_valid) begin
      check("m_row", m_row, exp_q[0].row);
      check("m_data", m_data, exp_q[0].data);
      check("m_last", m_last, exp_q.size() == 1);
    end
    check("outread_double", outread & last_or, 0);
    if (hold) begin
      check("hold_row", m_row, held_row);
      check("hold_data", m_data, held_data);
    end
    hold      = m_valid && !m_ready;
    held_row  = m_row;
    held_data = m_data;
    last_or   = outread;
    obs_hs    = m_valid && m_ready;
    if (outread) or_cycles.push_back(cyc);

    @(posedge clk);
    prev_ack = ack;
    new_ack  = !exp_valid && !ack && (rvalidport != 0);
    if (rst) begin
      beats_exp -= exp_q.size();
      exp_q.delete();
      ack = 1'b0;
    end else begin
      if (obs_hs) beats_seen++;
      if (exp_valid && m_ready) void'(exp_q.pop_front());
      if (new_ack) begin
        for (int r = 0; r < 8; r++) begin
          if (rvalidport[r]) exp_q.push_back('{row: r, data: routport[r]});
        end
        beats_exp += $countones(rvalidport);
      end
      ack = new_ack;
    end
    cyc++;

    #1;
    if (prev_ack) rvalidport = '0;
    if (!rst && rvalidport == 0 && core_q.size() != 0) begin
      set_t s;
      s          = core_q.pop_front();
      rvalidport = s.mask;
      routport   = s.data;
    end
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run_drain(input int bound);
    int n;
    n = 0;
    while ((core_q.size() != 0 || rvalidport != 0 || exp_q.size() != 0 || ack) && n < bound) begin
      cycle();
      n++;
    end
    check("drain_timeout", n < bound, 1);
    cycle();
    cycle();
  endtask

  task automatic push_set(input logic [7:0] mask, input logic [7:0][31:0] data);
    set_t s;
    s.mask = mask;
    s.data = data;
    core_q.push_back(s);
  endtask

  initial begin
    logic [7:0][31:0] d;
    int               b0, n;
    checks = 0; errors = 0; cyc = 0; beats_seen = 0; beats_exp = 0;
    ack = 1'b0; hold = 1'b0; last_or = 1'b0; ready_mode = 0;
    rst        = 1'b1;
    rvalidport = 8'hFF;
    m_ready    = 1'b1;
    for (int r = 0; r < 8; r++) routport[r] = 32'(100 + r);
    @(posedge clk);
    #1;

    // Reset held with every row valid: nothing may be acknowledged.
    repeat (3) begin
      cycle();
      check("rst_m_data", m_data, 0);
      check("rst_m_row", m_row, 0);
    end

    // Full capture straight out of reset, rows 100..107.
    rst = 1'b0;
    b0  = beats_seen;
    or_cycles.delete();
    run_drain(40);
    check("full_beats", beats_seen - b0, 8);
    check("full_acks", or_cycles.size(), 1);

    // Sparse mask 1010_0100 with data r*3.
    for (int r = 0; r < 8; r++) d[r] = 32'(r * 3);
    b0 = beats_seen;
    push_set(8'b1010_0100, d);
    run_drain(40);
    check("sparse_beats", beats_seen - b0, 3);

    // Backpressure: ready toggles every cycle.
    for (int r = 0; r < 8; r++) d[r] = 32'(100 + r);
    ready_mode = 1;
    b0 = beats_seen;
    push_set(8'hFF, d);
    run_drain(60);
    check("bp_beats", beats_seen - b0, 8);
    ready_mode = 0;
    m_ready    = 1'b1;

    // Back-to-back: second set re-asserted right after the first is cleared.
    d = '0; d[0] = 32'd1; d[1] = 32'd2;
    push_set(8'h03, d);
    d[0] = 32'd7; d[1] = 32'd9;
    push_set(8'h03, d);
    or_cycles.delete();
    b0 = beats_seen;
    run_drain(40);
    check("b2b_acks", or_cycles.size(), 2);
    if (or_cycles.size() == 2) check("b2b_gap_ok", (or_cycles[1] - or_cycles[0]) >= 3, 1);
    check("b2b_beats", beats_seen - b0, 4);

    // Randomised sets with random backpressure.
    ready_mode = 2;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] m;
      m = 8'($urandom_range(1, 255));
      for (int r = 0; r < 8; r++) d[r] = $urandom;
      push_set(m, d);
    end
    run_drain(2000);
    check("rand_beats_total", beats_seen, beats_exp);
    ready_mode = 0;
    m_ready    = 1'b1;

    // Reset after three of eight beats: remaining beats must vanish.
    for (int r = 0; r < 8; r++) d[r] = $urandom;
    push_set(8'hFF, d);
    b0 = beats_seen;
    n  = 0;
    while (beats_seen - b0 < 3 && n < 50) begin
      cycle();
      n++;
    end
    check("mid_rst_reach", beats_seen - b0, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    b0  = beats_seen;
    repeat (10) cycle();
    check("mid_rst_no_beats", beats_seen - b0, 0);
    check("mid_rst_busy", busy, 0);
    check("final_beats_total", beats_seen, beats_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
